// File: rtl/gray_counter_param.sv
// Parametrised up/down binary counter with Gray view, parallel load, wrap or saturate at
// the ends, sticky overflow/underflow flags and a registered one-cycle wrap pulse.
module gray_counter_param #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Bin,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wrap_q, wrap_d;

    logic at_max, at_zero, ovf_evt, udf_evt;

    assign at_max  = (cnt_q == MaxVal);
    assign at_zero = (cnt_q == '0);
    // Boundary events only count when a real step is requested; Load takes precedence.
    assign ovf_evt = !Load && En && Up && at_max;
    assign udf_evt = !Load && En && !Up && at_zero;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (Load) begin
            cnt_d = LoadVal;
        end else if (En) begin
            if (Up) begin
                if (at_max && SATURATE) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d  = cnt_q + One;
                    wrap_d = at_max;
                end
            end else begin
                if (at_zero && SATURATE) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d  = cnt_q - One;
                    wrap_d = at_zero;
                end
            end
        end
    end

    // Set beats clear when both land on the same edge.
    assign ovf_d = ovf_evt || (ovf_q && !ClrFlag);
    assign udf_d = udf_evt || (udf_q && !ClrFlag);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            wrap_q <= wrap_d;
        end
    end

    assign Bin       = cnt_q;
    assign Gray      = cnt_q ^ (cnt_q >> 1);
    assign Overflow  = ovf_q;
    assign Underflow = udf_q;
    assign Wrap      = wrap_q;

endmodule
